tqvp_prism_bridge: RTL and testbench



---
 rtl/tqvp_prism_pkg.sv | 32 +++
 rtl/tqvp_prism_bridge_if.sv | 20 ++
 rtl/prism_sync_fifo.sv | 64 ++++++
 rtl/tqvp_prism_bridge.sv | 169 ++++++++++++++++
 tb/tb_tqvp_prism_bridge.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tqvp_prism_pkg.sv
// Shared register offsets and bit positions for the PRISM bridge.
// Imported by the bridge top and visible to anything that decodes its map.
package tqvp_prism_pkg;

  localparam logic [5:0] ADDR_CTRL       = 6'h00;
  localparam logic [5:0] ADDR_STATUS     = 6'h04;
  localparam logic [5:0] ADDR_INT_STATUS = 6'h08;
  localparam logic [5:0] ADDR_INT_MASK   = 6'h0C;
  localparam logic [5:0] ADDR_TX_DATA    = 6'h10;
  localparam logic [5:0] ADDR_RX_DATA    = 6'h14;
  localparam logic [5:0] ADDR_EXTRA_IN   = 6'h18;
  localparam logic [5:0] ADDR_RX_THRESH  = 6'h1C;

  localparam int INT_W        = 4;
  localparam int INT_HALT     = 0;
  localparam int INT_RX_LVL   = 1;
  localparam int INT_TX_DRAIN = 2;
  localparam int INT_TX_DROP  = 3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_ENG_RESET = 1;
  localparam int CTRL_RX_FLUSH  = 2;
  localparam int CTRL_TX_FLUSH  = 3;

  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_HALT         = 16;
  localparam int ST_TX_FULL      = 17;
  localparam int ST_RX_EMPTY     = 18;

  localparam logic [4:0] RX_THRESH_RST = 5'd1;

endpackage

// File: rtl/tqvp_prism_bridge_if.sv
// TinyQV peripheral bus bundle: the CPU side drives the master modport,
// the bridge sits on the slave modport.
interface tqvp_prism_bridge_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/prism_sync_fifo.sv
// Single-clock FIFO with count output; flush clears pointers and count and
// overrides any push or pop issued in the same cycle.
module prism_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     count_nxt,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  always_comb begin
    w_do_push = push && !full;
    w_do_pop  = pop && !empty;
    count_nxt = r_count;
    if (flush)
      count_nxt = '0;
    else if (w_do_push && !w_do_pop)
      count_nxt = r_count + CW'(1);
    else if (w_do_pop && !w_do_push)
      count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !rst)
      r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tqvp_prism_bridge.sv
// TinyQV peripheral wrapper for a PRISM engine: control/status registers,
// TX/RX FIFOs, extra-input field and masked sticky interrupt sources.
module tqvp_prism_bridge
  import tqvp_prism_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int EXTRA_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           ui_in,
  output logic [7:0]           uo_out,
  tqvp_prism_bridge_if.slave   bus,
  output logic                 user_interrupt,
  output logic                 eng_reset,
  output logic                 eng_enable,
  output logic [7+EXTRA_W-1:0] eng_in_data,
  input  logic [6:0]           eng_out_data,
  input  logic                 eng_halt,
  output logic                 eng_tx_valid,
  output logic [DATA_W-1:0]    eng_tx_data,
  input  logic                 eng_tx_ready,
  input  logic                 eng_rx_valid,
  input  logic [DATA_W-1:0]    eng_rx_data,
  output logic                 eng_rx_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = (EXTRA_W > 0) ? EXTRA_W : 1;

  logic             r_enable;
  logic             r_eng_reset;
  logic [INT_W-1:0] r_int;
  logic [INT_W-1:0] r_mask;
  logic [EW-1:0]    r_extra;
  logic [4:0]       r_thresh;
  logic             r_halt_q;
  logic             r_irq;

  logic w_wr, w_rd;
  logic w_wr_ctrl, w_tx_flush, w_rx_flush, w_tx_push, w_rx_pop;
  logic [INT_W-1:0] w_set;
  logic [INT_W-1:0] w_w1c;
  logic [31:0]      w_rdata;

  logic [DATA_W-1:0] w_rx_head;
  logic [CW-1:0]     w_tx_count, w_tx_count_nxt, w_rx_count, w_rx_count_nxt;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic              w_unused;

  assign w_wr       = (bus.data_write_n == 2'b10);
  assign w_rd       = (bus.data_read_n != 2'b11);
  assign w_wr_ctrl  = w_wr && (bus.address == ADDR_CTRL);
  assign w_tx_flush = w_wr_ctrl && bus.data_in[CTRL_TX_FLUSH];
  assign w_rx_flush = w_wr_ctrl && bus.data_in[CTRL_RX_FLUSH];
  assign w_tx_push  = w_wr && (bus.address == ADDR_TX_DATA);
  assign w_rx_pop   = w_rd && (bus.address == ADDR_RX_DATA);
  assign w_w1c      = (w_wr && (bus.address == ADDR_INT_STATUS)) ? bus.data_in[INT_W-1:0] : '0;

  prism_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_tx_push),
    .push_data (bus.data_in[DATA_W-1:0]),
    .pop       (eng_tx_ready),
    .flush     (w_tx_flush),
    .head      (eng_tx_data),
    .count     (w_tx_count),
    .count_nxt (w_tx_count_nxt),
    .full      (w_tx_full),
    .empty     (w_tx_empty)
  );

  prism_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (eng_rx_valid),
    .push_data (eng_rx_data),
    .pop       (w_rx_pop),
    .flush     (w_rx_flush),
    .head      (w_rx_head),
    .count     (w_rx_count),
    .count_nxt (w_rx_count_nxt),
    .full      (w_rx_full),
    .empty     (w_rx_empty)
  );

  // Level and drain events look at the count the FIFO is about to take, so
  // the sticky bit lands on the same edge as the count change.
  always_comb begin
    w_set               = '0;
    w_set[INT_HALT]     = eng_halt && !r_halt_q;
    w_set[INT_RX_LVL]   = (5'(w_rx_count) < r_thresh) && (5'(w_rx_count_nxt) >= r_thresh);
    w_set[INT_TX_DRAIN] = (w_tx_count == CW'(1)) && (w_tx_count_nxt == '0) && !w_tx_flush;
    w_set[INT_TX_DROP]  = w_tx_push && w_tx_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable    <= 1'b0;
      r_eng_reset <= 1'b0;
      r_int       <= '0;
      r_mask      <= '0;
      r_extra     <= '0;
      r_thresh    <= RX_THRESH_RST;
      r_halt_q    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable    <= bus.data_in[CTRL_ENABLE];
        r_eng_reset <= bus.data_in[CTRL_ENG_RESET];
      end
      if (w_wr && (bus.address == ADDR_INT_MASK))
        r_mask <= bus.data_in[INT_W-1:0];
      if (w_wr && (bus.address == ADDR_EXTRA_IN) && (EXTRA_W > 0))
        r_extra <= bus.data_in[EW-1:0];
      if (w_wr && (bus.address == ADDR_RX_THRESH))
        r_thresh <= bus.data_in[4:0];
      r_int    <= (r_int & ~w_w1c) | w_set;
      r_halt_q <= eng_halt;
      r_irq    <= |(r_int & r_mask);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        w_rdata[CTRL_ENABLE]    = r_enable;
        w_rdata[CTRL_ENG_RESET] = r_eng_reset;
      end
      ADDR_STATUS: begin
        w_rdata[4:0]                           = 5'(w_tx_count);
        w_rdata[ST_RX_COUNT_LSB+4:ST_RX_COUNT_LSB] = 5'(w_rx_count);
        w_rdata[ST_HALT]                       = eng_halt;
        w_rdata[ST_TX_FULL]                    = w_tx_full;
        w_rdata[ST_RX_EMPTY]                   = w_rx_empty;
      end
      ADDR_INT_STATUS: w_rdata[INT_W-1:0] = r_int;
      ADDR_INT_MASK:   w_rdata[INT_W-1:0] = r_mask;
      ADDR_RX_DATA:    if (!w_rx_empty) w_rdata[DATA_W-1:0] = w_rx_head;
      ADDR_EXTRA_IN:   w_rdata[EW-1:0] = r_extra;
      ADDR_RX_THRESH:  w_rdata[4:0] = r_thresh;
      default:         w_rdata = '0;
    endcase
  end

  assign bus.data_out   = w_rdata;
  assign bus.data_ready = 1'b1;

  generate
    if (EXTRA_W > 0) begin : g_extra
      assign eng_in_data = {r_extra, ui_in[6:0]};
    end else begin : g_no_extra
      assign eng_in_data = ui_in[6:0];
    end
  endgenerate

  assign uo_out         = {eng_out_data, 1'b0};
  assign user_interrupt = r_irq;
  assign eng_reset      = r_eng_reset;
  assign eng_enable     = r_enable;
  assign eng_tx_valid   = !w_tx_empty;
  assign eng_rx_ready   = !w_rx_full;
  assign w_unused       = ^{bus.data_in, ui_in[7], r_extra, w_rx_full};

endmodule

// File: tb/tb_tqvp_prism_bridge.sv
// Scenario bench for tqvp_prism_bridge with queue scoreboards for both FIFOs.
module tb_tqvp_prism_bridge;
  import tqvp_prism_pkg::*;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int EXTRA_W = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic        user_interrupt;
  logic        eng_reset, eng_enable;
  logic [15:0] eng_in_data;
  logic [6:0]  eng_out_data;
  logic        eng_halt;
  logic        eng_tx_valid;
  logic [7:0]  eng_tx_data;
  logic        eng_tx_ready;
  logic        eng_rx_valid;
  logic [7:0]  eng_rx_data;
  logic        eng_rx_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  tqvp_prism_bridge_if bus_if ();

  tqvp_prism_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EXTRA_W(EXTRA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus_if),
    .user_interrupt (user_interrupt),
    .eng_reset      (eng_reset),
    .eng_enable     (eng_enable),
    .eng_in_data    (eng_in_data),
    .eng_out_data   (eng_out_data),
    .eng_halt       (eng_halt),
    .eng_tx_valid   (eng_tx_valid),
    .eng_tx_data    (eng_tx_data),
    .eng_tx_ready   (eng_tx_ready),
    .eng_rx_valid   (eng_rx_valid),
    .eng_rx_data    (eng_rx_data),
    .eng_rx_ready   (eng_rx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address      = a;
    bus_if.data_in      = d;
    bus_if.data_write_n = 2'b10;
    @(posedge clk); #1;
    bus_if.data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.address     = a;
    bus_if.data_read_n = 2'b10;
    #1 d = bus_if.data_out;
    @(posedge clk); #1;
    bus_if.data_read_n = 2'b11;
  endtask

  task automatic eng_push(input logic [7:0] d);
    @(negedge clk);
    eng_rx_valid = 1'b1;
    eng_rx_data  = d;
    @(posedge clk); #1;
    eng_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0]  addrs [10];
    logic [31:0] exps  [10];
    logic [31:0] rd;
    addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h3C};
    exps  = '{32'h0, 32'h0004_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if ({user_interrupt, eng_tx_valid, eng_rx_ready, eng_enable, eng_reset} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_outputs: irq/txv/rxr/en/rst got %b want 00100",
               {user_interrupt, eng_tx_valid, eng_rx_ready, eng_enable, eng_reset});
    end
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo_out: got %h want 00", uo_out);
    end
    for (int i = 0; i < 10; i++) begin
      bus_read(addrs[i], rd);
      checks++;
      if (rd !== exps[i]) begin
        errors++;
        $display("FAIL reset_reg_%h: got %h want %h", addrs[i], rd, exps[i]);
      end
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd;
    int model_cnt = 0;
    int pops = 0;
    logic [31:0] exp_int = 0;
    eng_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_write(ADDR_TX_DATA, 32'hFFFF_FFA5);
      if (model_cnt < DEPTH) begin
        tx_q.push_back(8'hA5);
        model_cnt++;
      end else begin
        exp_int[INT_TX_DROP] = 1'b1;
      end
    end
    bus_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== (32'(model_cnt) | (32'(model_cnt == DEPTH) << 17) | 32'h0004_0000)) begin
      errors++;
      $display("FAIL tx_full_status: got %h want %h", rd,
               32'(model_cnt) | (32'(model_cnt == DEPTH) << 17) | 32'h0004_0000);
    end
    bus_read(ADDR_INT_STATUS, rd);
    checks++;
    if (rd !== exp_int) begin
      errors++;
      $display("FAIL tx_drop_int: got %h want %h", rd, exp_int);
    end
    @(negedge clk) eng_tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      #1;
      if (eng_tx_valid) begin
        checks++;
        if (eng_tx_data !== tx_q[0]) begin
          errors++;
          $display("FAIL tx_pop_data: got %h want %h", eng_tx_data, tx_q[0]);
        end
        void'(tx_q.pop_front());
        pops++;
      end
      @(negedge clk);
    end
    eng_tx_ready = 1'b0;
    exp_int[INT_TX_DRAIN] = 1'b1;
    checks++;
    if (tx_q.size() != 0 || pops != DEPTH) begin
      errors++;
      $display("FAIL tx_drain_budget: popped %0d want %0d", pops, DEPTH);
      tx_q.delete();
    end
    #1;
    checks++;
    if (eng_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_valid_after_drain: got %b want 0", eng_tx_valid);
    end
    bus_read(ADDR_INT_STATUS, rd);
    checks++;
    if (rd !== exp_int) begin
      errors++;
      $display("FAIL tx_drain_int: got %h want %h", rd, exp_int);
    end
    bus_write(ADDR_INT_STATUS, 32'hF);
    bus_read(ADDR_INT_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL int_w1c_clear: got %h want 0", rd);
    end
  endtask

  task automatic test_rx_threshold();
    logic [31:0] rd;
    logic [31:0] exp;
    bus_write(ADDR_RX_THRESH, 32'h2);
    bus_write(ADDR_INT_MASK, 32'h2);
    bus_read(ADDR_RX_THRESH, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL rx_thresh_rw: got %h want 2", rd);
    end
    eng_push(8'h11); rx_q.push_back(8'h11);
    eng_push(8'h22); rx_q.push_back(8'h22);
    checks++;
    if (user_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL rx_irq_early: got %b want 0", user_interrupt);
    end
    @(posedge clk); #1;
    checks++;
    if (user_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL rx_irq_latency: got %b want 1", user_interrupt);
    end
    for (int i = 0; i < 3; i++) begin
      exp = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'h0;
      bus_read(ADDR_RX_DATA, rd);
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL rx_read_%0d: got %h want %h", i, rd, exp);
      end
    end
    bus_write(ADDR_INT_STATUS, 32'h2);
    bus_write(ADDR_INT_MASK, 32'h0);
  endtask

  task automatic test_halt();
    logic [31:0] rd;
    bus_write(ADDR_INT_MASK, 32'h1);
    @(negedge clk) eng_halt = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (user_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL halt_irq_early: got %b want 0", user_interrupt);
    end
    @(posedge clk); #1;
    checks++;
    if (user_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL halt_irq: got %b want 1", user_interrupt);
    end
    @(negedge clk) eng_halt = 1'b0;
    @(negedge clk);
    eng_halt            = 1'b1;
    bus_if.address      = ADDR_INT_STATUS;
    bus_if.data_in      = 32'h1;
    bus_if.data_write_n = 2'b10;
    @(posedge clk); #1;
    bus_if.data_write_n = 2'b11;
    bus_read(ADDR_INT_STATUS, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL halt_set_beats_w1c: got %h want 1", rd);
    end
    bus_write(ADDR_INT_STATUS, 32'h1);
    bus_read(ADDR_INT_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL halt_w1c_level: got %h want 0", rd);
    end
    @(negedge clk) eng_halt = 1'b0;
    bus_write(ADDR_INT_MASK, 32'h0);
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    bus_write(ADDR_CTRL, 32'h3);
    checks++;
    if ({eng_enable, eng_reset} !== 2'b11) begin
      errors++;
      $display("FAIL ctrl_outputs: got %b want 11", {eng_enable, eng_reset});
    end
    eng_tx_ready = 1'b0;
    bus_write(ADDR_TX_DATA, 32'h77);
    bus_write(ADDR_CTRL, 32'h2);
    bus_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h0004_0001) begin
      errors++;
      $display("FAIL eng_reset_no_flush: got %h want 00040001", rd);
    end
    bus_write(ADDR_CTRL, 32'hA);
    bus_read(ADDR_CTRL, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL ctrl_flush_reads_0: got %h want 2", rd);
    end
    bus_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h0004_0000 || eng_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_flush: status %h valid %b want 00040000 0", rd, eng_tx_valid);
    end
    bus_read(ADDR_INT_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL tx_flush_no_drain_int: got %h want 0", rd);
    end
    bus_write(ADDR_CTRL, 32'h0);
  endtask

  task automatic test_rx_flush();
    logic [31:0] rd;
    for (int i = 0; i < DEPTH; i++) begin
      eng_push(8'h10 + 8'(i));
      rx_q.push_back(8'h10 + 8'(i));
    end
    checks++;
    if (eng_rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_ready: got %b want 0", eng_rx_ready);
    end
    bus_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== (32'(rx_q.size()) << 8)) begin
      errors++;
      $display("FAIL rx_full_status: got %h want %h", rd, 32'(rx_q.size()) << 8);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      eng_rx_valid        = 1'b1;
      eng_rx_data         = 8'h99;
      bus_if.address      = ADDR_CTRL;
      bus_if.data_in      = 32'h4;
      bus_if.data_write_n = 2'b10;
      @(posedge clk); #1;
      eng_rx_valid        = 1'b0;
      bus_if.data_write_n = 2'b11;
      rx_q.delete();
      bus_read(ADDR_STATUS, rd);
      checks++;
      if (rd !== 32'h0004_0000 || eng_rx_ready !== 1'b1) begin
        errors++;
        $display("FAIL rx_flush_%0d: status %h ready %b want 00040000 1", k, rd, eng_rx_ready);
      end
    end
    bus_write(ADDR_INT_STATUS, 32'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] exp;
    eng_push(8'h33); rx_q.push_back(8'h33);
    @(negedge clk);
    eng_rx_valid       = 1'b1;
    eng_rx_data        = 8'h44;
    bus_if.address     = ADDR_RX_DATA;
    bus_if.data_read_n = 2'b10;
    #1 rd = bus_if.data_out;
    exp = 32'(rx_q.pop_front());
    rx_q.push_back(8'h44);
    @(posedge clk); #1;
    eng_rx_valid       = 1'b0;
    bus_if.data_read_n = 2'b11;
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL b2b_read: got %h want %h", rd, exp);
    end
    bus_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== (32'(rx_q.size()) << 8)) begin
      errors++;
      $display("FAIL b2b_count: got %h want %h", rd, 32'(rx_q.size()) << 8);
    end
    exp = 32'(rx_q.pop_front());
    bus_read(ADDR_RX_DATA, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL b2b_second: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_extra();
    logic [31:0] rd;
    bus_write(ADDR_EXTRA_IN, 32'h1FF);
    @(negedge clk);
    ui_in        = 8'h55;
    eng_out_data = 7'h5A;
    #1;
    checks++;
    if (eng_in_data !== 16'hFFD5) begin
      errors++;
      $display("FAIL eng_in_data: got %h want FFD5", eng_in_data);
    end
    checks++;
    if (uo_out !== 8'hB4) begin
      errors++;
      $display("FAIL uo_out: got %h want B4", uo_out);
    end
    bus_write(ADDR_EXTRA_IN, 32'hFFFF_FE02);
    bus_read(ADDR_EXTRA_IN, rd);
    checks++;
    if (rd !== 32'h002) begin
      errors++;
      $display("FAIL extra_width_mask: got %h want 002", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    eng_tx_ready = 1'b0;
    bus_write(ADDR_TX_DATA, 32'h12);
    eng_push(8'h34);
    bus_write(ADDR_RX_THRESH, 32'h7);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    bus_read(ADDR_STATUS, rd);
    checks++;
    if (rd !== 32'h0004_0000 || eng_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fifos: status %h valid %b want 00040000 0", rd, eng_tx_valid);
    end
    bus_read(ADDR_RX_THRESH, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL reset_mid_thresh: got %h want 1", rd);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    ui_in               = 8'h00;
    eng_out_data        = 7'h00;
    eng_halt            = 1'b0;
    eng_tx_ready        = 1'b0;
    eng_rx_valid        = 1'b0;
    eng_rx_data         = 8'h00;
    bus_if.address      = 6'h00;
    bus_if.data_in      = 32'h0;
    bus_if.data_write_n = 2'b11;
    bus_if.data_read_n  = 2'b11;

    test_reset();
    test_tx_overflow();
    test_rx_threshold();
    test_halt();
    test_ctrl();
    test_rx_flush();
    test_back_to_back();
    test_extra();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
